// File: rtl/signed_minmax_tracker.sv
// Tracks signed min/max and a saturating sample count over a frame of 6-bit samples.
// Latency: result (out_valid) appears one clock after the sample flagged in_last is accepted.
// Backpressure: in_ready drops while a result is held; it returns once out_ready drains the result.
module signed_minmax_tracker #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [5:0]       in_data,
    input  logic             in_last,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [5:0]       out_min,
    output logic [5:0]       out_max,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [5:0]       min_q, min_d;
    logic [5:0]       max_q, max_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic             accept;

    // Two's complement a < b: differing signs decide directly, otherwise the
    // low five bits order the values the same way for both signs.
    function automatic logic slt(input logic [5:0] a, input logic [5:0] b);
        if (a[5] != b[5]) begin
            slt = a[5];
        end else begin
            slt = (a[4:0] < b[4:0]);
        end
    endfunction

    // in_ready is a pure state decode so out_ready never reaches it combinationally.
    assign in_ready  = (state_q != ST_HOLD);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;

    assign out_min   = min_q;
    assign out_max   = max_q;
    assign out_count = cnt_q;
    assign out_sat   = sat_q;

    // Next-state and datapath update for the frame accumulator.
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    min_d   = in_data;
                    max_d   = in_data;
                    cnt_d   = CNT_ONE;
                    sat_d   = 1'b0;
                    state_d = in_last ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (accept) begin
                    // Strict compares leave ties on the held value.
                    if (slt(in_data, min_q)) begin
                        min_d = in_data;
                    end
                    if (slt(max_q, in_data)) begin
                        max_d = in_data;
                    end
                    if (cnt_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                    if (in_last) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any accept or handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            min_q   <= 6'd0;
            max_q   <= 6'd0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_signed_minmax_tracker.sv
// Directed bench for signed_minmax_tracker with hand-computed expectations.
// Inputs change 1 ns after the rising edge; outputs are sampled at the same point.
// Backpressure is exercised by holding out_ready low while in_valid stays high.
module tb_signed_minmax_tracker;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [5:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_ready;
    logic       out_valid;
    logic [5:0] out_min;
    logic [5:0] out_max;
    logic [3:0] out_count;
    logic       out_sat;

    int n_checks;
    int n_pass;

    signed_minmax_tracker #(.CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_min   (out_min),
        .out_max   (out_max),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for exactly one edge (caller ensures in_ready is high).
    task automatic send(input int v, input logic last);
        in_valid = 1'b1;
        in_data  = 6'(v);
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_result(input string tag, input int mn, input int mx, input int cnt, input int sat);
        chk({tag, ".valid"}, int'(out_valid), 1);
        chk({tag, ".min"},   $signed(out_min), mn);
        chk({tag, ".max"},   $signed(out_max), mx);
        chk({tag, ".count"}, int'(out_count), cnt);
        chk({tag, ".sat"},   int'(out_sat), sat);
    endtask

    // Consume the held result and confirm the block is back to accepting.
    task automatic drain(input string tag);
        out_ready = 1'b1;
        tick();
        chk({tag, ".drain_valid"}, int'(out_valid), 0);
        chk({tag, ".drain_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 6'd0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst.ready", int'(in_ready), 1);
        chk("rst.valid", int'(out_valid), 0);
        chk("rst.min",   $signed(out_min), 0);
        chk("rst.max",   $signed(out_max), 0);
        chk("rst.count", int'(out_count), 0);
        chk("rst.sat",   int'(out_sat), 0);

        // in_last without in_valid does nothing
        in_last = 1'b1;
        tick();
        in_last = 1'b0;
        chk("lastonly.valid", int'(out_valid), 0);
        chk("lastonly.count", int'(out_count), 0);

        // Mixed frame 5, -3, 31, -32
        send(5, 1'b0);
        send(-3, 1'b0);
        chk("mixed.mid_valid", int'(out_valid), 0);
        send(31, 1'b0);
        send(-32, 1'b1);
        chk_result("mixed", -32, 31, 4, 0);
        chk("mixed.hold_ready", int'(in_ready), 0);
        drain("mixed");

        // Single-sample frame
        send(-1, 1'b1);
        chk_result("single", -1, -1, 1, 0);
        drain("single");

        // Ties across the sign boundary
        send(0, 1'b0);
        send(0, 1'b0);
        send(-1, 1'b0);
        send(0, 1'b1);
        chk_result("ties", -1, 0, 4, 0);
        drain("ties");

        // Same-sign pair
        send(3, 1'b0);
        send(7, 1'b1);
        chk_result("pos_pair", 3, 7, 2, 0);
        drain("pos_pair");

        // Same-sign negative pair, larger first
        send(-5, 1'b0);
        send(-20, 1'b1);
        chk_result("neg_pair", -20, -5, 2, 0);
        drain("neg_pair");

        // Saturation: 17 samples of 2
        for (int i = 0; i < 17; i++) begin
            send(2, (i == 16) ? 1'b1 : 1'b0);
        end
        chk_result("sat", 2, 2, 15, 1);
        drain("sat");
        send(1, 1'b1);
        chk_result("post_sat", 1, 1, 1, 0);
        drain("post_sat");

        // Back-pressure with a pending sample in HOLD
        out_ready = 1'b0;
        send(9, 1'b1);
        chk_result("bp", 9, 9, 1, 0);
        in_valid = 1'b1;
        in_data  = 6'(-7);
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp.ready", int'(in_ready), 0);
            chk("bp.valid", int'(out_valid), 1);
            chk("bp.min",   $signed(out_min), 9);
            chk("bp.count", int'(out_count), 1);
        end
        out_ready = 1'b1;
        tick();
        chk("bp.idle_valid", int'(out_valid), 0);
        chk("bp.idle_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk_result("bp_pending", -7, -7, 1, 0);
        drain("bp_pending");

        // Reset mid-frame
        send(10, 1'b0);
        send(20, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst.valid", int'(out_valid), 0);
        chk("midrst.ready", int'(in_ready), 1);
        chk("midrst.min",   $signed(out_min), 0);
        chk("midrst.max",   $signed(out_max), 0);
        chk("midrst.count", int'(out_count), 0);
        send(4, 1'b1);
        chk_result("midrst_new", 4, 4, 1, 0);

        // Reset in HOLD beats a concurrent handshake
        out_ready = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 6'd12;
        in_last   = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("holdrst.valid", int'(out_valid), 0);
        chk("holdrst.count", int'(out_count), 0);
        chk("holdrst.max",   $signed(out_max), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/signed_minmax_tracker.md
SIGNED_MINMAX_TRACKER -- requirements
Module: signed_minmax_tracker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports clk and reset.
REQ-002 Parameter CNT_W SHALL default to 4 and set the sample-count width.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-005 in_valid  input  1  upstream sample present.
REQ-006 in_data  input  6  sample, two's complement, range -32..+31.
REQ-007 in_last  input  1  qualifies in_data as the final sample of a frame.
REQ-008 in_ready  output  1  block can accept a sample this cycle.
REQ-009 out_ready  input  1  downstream accepts the frame result.
REQ-010 out_valid  output  1  frame result is held and valid.
REQ-011 out_min  output  6  signed minimum of the frame.
REQ-012 out_max  output  6  signed maximum of the frame.
REQ-013 out_count  output  CNT_W  number of samples in the frame, saturating.
REQ-014 out_sat  output  1  set when the frame count exceeded 2^CNT_W-1.

Function
REQ-015 A sample SHALL be accepted only in a cycle where in_valid and in_ready are both high.
REQ-016 The FSM SHALL have exactly three states: IDLE, ACCUM and HOLD.
REQ-017 In IDLE and ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-018 In HOLD, in_ready SHALL be 0 and out_valid SHALL be 1.
REQ-019 IDLE accept SHALL load min and max with the sample, set count=1 and clear sat.
REQ-020 From IDLE, an accept with in_last=1 SHALL go to HOLD; otherwise an accept SHALL go to ACCUM.
REQ-021 In ACCUM, an accept SHALL replace min when sample < min, using a signed two's complement less-than.
REQ-022 In ACCUM, an accept SHALL replace max when max < sample, using the same signed less-than.
REQ-023 Signed less-than rules:
  - sign bits differ: the operand with sign=1 is the lesser;
  - sign bits equal: compare bits [4:0] as unsigned magnitudes.
REQ-024 On equal values, min and max SHALL keep their held value (no update).
REQ-025 In ACCUM, an accept SHALL increment count.
REQ-026 At count = 2^CNT_W-1, a further accept SHALL hold count and set sat, which stays set until the next IDLE accept.
REQ-027 An ACCUM accept with in_last=1 SHALL go to HOLD; ACCUM otherwise holds state.
REQ-028 out_valid SHALL rise on the cycle after the last sample is accepted; latency is 1 clock.
REQ-029 out_min, out_max, out_count and out_sat SHALL be registered and stable throughout HOLD.
REQ-030 HOLD with out_ready=1 SHALL go to IDLE; out_valid is 0 from the next cycle.
REQ-031 HOLD with out_ready=0 SHALL stay in HOLD indefinitely, holding all outputs.
REQ-032 in_valid in HOLD SHALL be ignored (back-pressure) and the sample SHALL NOT be consumed.
REQ-033 in_last without in_valid SHALL have no effect.
REQ-034 No combinational path SHALL exist from out_ready to in_ready; in_ready depends on state only.

Reset
REQ-035 Reset SHALL force state=IDLE, out_valid=0, out_min=0, out_max=0, out_count=0 and out_sat=0 on the next edge.
REQ-036 Reset SHALL take priority over all accepts and handshakes in the same cycle.
REQ-037 Reset mid-frame or in HOLD SHALL discard the partial or held result with no output.
REQ-038 After reset, in_ready SHALL be 1 from the first cycle following reset deassertion.

Verification
REQ-039 Mixed frame: samples 5, -3, 31, -32 (last) with out_ready=1 -> one cycle later out_valid=1, out_min=6'b100000, out_max=6'b011111, out_count=4, out_sat=0.
REQ-040 Single-sample frame: sample -1 with in_last=1 -> out_min=out_max=6'b111111, out_count=1.
REQ-041 Ties and sign boundary: samples 0, 0, -1, 0 (last) -> out_min=-1, out_max=0; same-sign pair 3, 7 -> out_min=3, out_max=7.
REQ-042 Saturation with CNT_W=4: 17 samples of value 2 -> out_count=15 and out_sat=1; the next frame of 1 sample -> out_count=1, out_sat=0.
REQ-043 Back-pressure: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 -> in_ready=0 and outputs stable; out_ready=1 -> IDLE next cycle, and the pending sample is accepted there.
REQ-044 Reset mid-frame: after 2 samples assert reset -> outputs zero, state IDLE; a new frame 4 (last) -> out_min=out_max=4, out_count=1.
